// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet link-speed controller: speed codes,
// FSM state encodings and per-speed transmit divider constants.
package eth_pkg;

  typedef enum logic [1:0] {
    SPEED_10   = 2'b00,
    SPEED_100  = 2'b01,
    SPEED_1000 = 2'b10,
    SPEED_RSVD = 2'b11
  } speed_e;

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_PAUSE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_GATED = 3'd3,
    ST_LOAD  = 3'd4
  } state_e;

  localparam int DIV_W = 6;

  localparam logic [DIV_W-1:0] P_10  = 6'd50;
  localparam logic [DIV_W-1:0] H_10  = 6'd25;
  localparam logic [DIV_W-1:0] Q_10  = 6'd12;
  localparam logic [DIV_W-1:0] P_100 = 6'd5;
  localparam logic [DIV_W-1:0] H_100 = 6'd2;
  localparam logic [DIV_W-1:0] Q_100 = 6'd1;

  typedef struct packed {
    logic [DIV_W-1:0] half;
    logic [DIV_W-1:0] quarter;
  } phase_t;

  // 1000M never runs the divider; a period of 1 keeps the counter pinned at 0.
  function automatic logic [DIV_W-1:0] period_of(input logic [1:0] speed);
    case (speed)
      SPEED_100:  period_of = P_100;
      SPEED_1000: period_of = 6'd1;
      default:    period_of = P_10;
    endcase
  endfunction

  function automatic phase_t phases_of(input logic [DIV_W-1:0] period);
    case (period)
      P_10:    phases_of = '{half: H_10,  quarter: Q_10};
      P_100:   phases_of = '{half: H_100, quarter: Q_100};
      default: phases_of = '{half: period >> 1, quarter: period >> 2};
    endcase
  endfunction

endpackage

// File: rtl/eth_speed_ctrl_clk_gen.sv
// Transmit clock divider: wrapping period counter with registered tx_clk and
// tx_clk90 compares; halt parks everything low, reload restarts from count 0.
module eth_clk_gen
  import eth_pkg::*;
(
  input  logic             rx_clk125,
  input  logic             reset,
  input  logic [DIV_W-1:0] period,
  input  logic             halt,
  input  logic             reload,
  output logic             tx_clk,
  output logic             tx_clk90,
  output logic             last
);

  logic [DIV_W-1:0] cnt_p0;
  logic [DIV_W-1:0] cnt_use;
  phase_t           ph;

  assign ph      = phases_of(period);
  assign cnt_use = reload ? '0 : cnt_p0;
  assign last    = (cnt_p0 == period - DIV_W'(1));

  // Stage p0 -> p1: counter compares land in the clock output registers.
  always_ff @(posedge rx_clk125 or posedge reset) begin
    if (reset) begin
      cnt_p0   <= '0;
      tx_clk   <= 1'b0;
      tx_clk90 <= 1'b0;
    end else if (halt) begin
      cnt_p0   <= '0;
      tx_clk   <= 1'b0;
      tx_clk90 <= 1'b0;
    end else begin
      cnt_p0   <= (cnt_use == period - DIV_W'(1)) ? '0 : cnt_use + DIV_W'(1);
      tx_clk   <= (cnt_use < ph.half);
      tx_clk90 <= (cnt_use >= ph.quarter) && (cnt_use < ph.quarter + ph.half);
    end
  end

endmodule

// File: rtl/eth_speed_ctrl.sv
// Ethernet link-speed controller: pauses TX, drains and gates the divider,
// settles, then reloads the new period. Define ETH_SPEED_CTRL_TIMEOUT_EN for a tx_idle watchdog.
module eth_speed_ctrl
  import eth_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned IDLE_TIMEOUT  = 4096
) (
  input  logic       rx_clk125,
  input  logic       reset,
  input  logic [1:0] speed_req,
  input  logic       tx_idle,
  output logic       tx_pause,
  output logic [1:0] cur_speed,
  output logic       gmii_mode,
  output logic       busy,
  output logic       timeout_err,
  output logic       tx_clk,
  output logic       tx_clk90
);

  // One counter serves both the settle window and the idle watchdog.
  localparam int unsigned WAIT_MAX = (SETTLE_CYCLES > IDLE_TIMEOUT) ? SETTLE_CYCLES : IDLE_TIMEOUT;
  localparam int          WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] SETTLE_LAST = WAIT_W'(SETTLE_CYCLES - 1);
`ifdef ETH_SPEED_CTRL_TIMEOUT_EN
  localparam logic [WAIT_W-1:0] IDLE_LAST = WAIT_W'(IDLE_TIMEOUT - 1);
`endif

  state_e            state;
  speed_e            target;
  speed_e            eff_speed;
  logic [WAIT_W-1:0] wait_cnt;
  logic [DIV_W-1:0]  div_period;
  logic              div_halt;
  logic              div_reload;
  logic              div_last;

  // During LOAD the divider already runs at the target rate so the first new edge follows LOAD directly.
  assign eff_speed  = (state == ST_LOAD) ? target : speed_e'(cur_speed);
  assign div_period = period_of(eff_speed);
  assign div_halt   = (state == ST_GATED) || (eff_speed == SPEED_1000);
  assign div_reload = (state == ST_LOAD);

  eth_clk_gen u_clk_gen (
    .rx_clk125 (rx_clk125),
    .reset     (reset),
    .period    (div_period),
    .halt      (div_halt),
    .reload    (div_reload),
    .tx_clk    (tx_clk),
    .tx_clk90  (tx_clk90),
    .last      (div_last)
  );

`ifndef ETH_SPEED_CTRL_TIMEOUT_EN
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge rx_clk125 or posedge reset) begin
    if (reset) begin
      state     <= ST_RUN;
      target    <= SPEED_10;
      cur_speed <= SPEED_10;
      tx_pause  <= 1'b0;
      busy      <= 1'b0;
      gmii_mode <= 1'b0;
      wait_cnt  <= '0;
`ifdef ETH_SPEED_CTRL_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
    end else begin
      unique case (state)
        ST_RUN: begin
          if ((speed_req != cur_speed) && (speed_req != SPEED_RSVD)) begin
            target   <= speed_e'(speed_req);
            tx_pause <= 1'b1;
            busy     <= 1'b1;
            wait_cnt <= '0;
            state    <= ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (tx_idle) begin
            state <= ST_DRAIN;
          end
`ifdef ETH_SPEED_CTRL_TIMEOUT_EN
          else if (wait_cnt == IDLE_LAST) begin
            timeout_err <= 1'b1;
            state       <= ST_DRAIN;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
`endif
        end
        // Stop only at the end of a period, where both clocks are already low.
        ST_DRAIN: begin
          if (div_last || (cur_speed == SPEED_1000)) begin
            gmii_mode <= 1'b0;
            wait_cnt  <= '0;
            state     <= ST_GATED;
          end
        end
        ST_GATED: begin
          if (wait_cnt == SETTLE_LAST) begin
            state <= ST_LOAD;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ST_LOAD: begin
          cur_speed <= target;
          gmii_mode <= (target == SPEED_1000);
          tx_pause  <= 1'b0;
          busy      <= 1'b0;
          state     <= ST_RUN;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_speed_ctrl.sv
// Directed bench for eth_speed_ctrl: table of speed switches plus hand sequences
// for reserved codes, back-to-back switches, idle stall and reset mid-switch.
module tb_eth_speed_ctrl;

  logic       rx_clk125 = 1'b0;
  logic       reset     = 1'b1;
  logic [1:0] speed_req = 2'b00;
  logic       tx_idle   = 1'b1;
  logic       tx_pause, gmii_mode, busy, timeout_err, tx_clk, tx_clk90;
  logic [1:0] cur_speed;

  int n_cmp = 0;
  int n_bad = 0;

  int lowrun, maxlow, hirun, minhi;
  int bcyc, hi, lo, lag, highs, drops, found, terr_mid;

  typedef struct {
    logic [1:0] req;
    logic [1:0] exp_speed;
    logic       exp_gmii;
    int         exp_busy;
    int         exp_min_hi;
    int         exp_hi;
    int         exp_lo;
    int         exp_lag;
  } sw_vec_t;

  sw_vec_t vecs [6];

  eth_speed_ctrl #(.SETTLE_CYCLES(16), .IDLE_TIMEOUT(4096)) dut (
    .rx_clk125   (rx_clk125),
    .reset       (reset),
    .speed_req   (speed_req),
    .tx_idle     (tx_idle),
    .tx_pause    (tx_pause),
    .cur_speed   (cur_speed),
    .gmii_mode   (gmii_mode),
    .busy        (busy),
    .timeout_err (timeout_err),
    .tx_clk      (tx_clk),
    .tx_clk90    (tx_clk90)
  );

  always #4 rx_clk125 = ~rx_clk125;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge rx_clk125);
    #1;
  endtask

  task automatic track();
    if (tx_clk === 1'b0 && tx_clk90 === 1'b0) begin
      lowrun++;
      if (lowrun > maxlow) maxlow = lowrun;
    end else begin
      lowrun = 0;
    end
    if (tx_clk === 1'b1) begin
      hirun++;
    end else begin
      if (hirun > 0 && hirun < minhi) minhi = hirun;
      hirun = 0;
    end
  endtask

  // Returns at the first high cycle after a full high/low period.
  task automatic measure(output int mhi, output int mlo, output int mlag);
    int t = 0;
    mhi = 0; mlo = 0; mlag = -1;
    while (tx_clk !== 1'b0 && t < 200) begin tick(); t++; end
    while (tx_clk !== 1'b1 && t < 200) begin tick(); t++; end
    while (tx_clk === 1'b1 && t < 300) begin
      if (mlag < 0 && tx_clk90 === 1'b1) mlag = mhi;
      mhi++; tick(); t++;
    end
    while (tx_clk === 1'b0 && t < 400) begin
      if (mlag < 0 && tx_clk90 === 1'b1) mlag = mhi + mlo;
      mlo++; tick(); t++;
    end
  endtask

  task automatic check_wave(input string tag, input int ehi, input int elo, input int elag);
    measure(hi, lo, lag);
    chk({tag, "_hi"}, hi, ehi);
    chk({tag, "_lo"}, lo, elo);
    chk({tag, "_lag90"}, lag, elag);
  endtask

  initial begin
    vecs[0] = '{req: 2'b01, exp_speed: 2'b01, exp_gmii: 1'b0, exp_busy: 65, exp_min_hi: 25, exp_hi: 2,  exp_lo: 3,  exp_lag: 1};
    vecs[1] = '{req: 2'b10, exp_speed: 2'b10, exp_gmii: 1'b1, exp_busy: 20, exp_min_hi: 2,  exp_hi: 0,  exp_lo: 0,  exp_lag: 0};
    vecs[2] = '{req: 2'b00, exp_speed: 2'b00, exp_gmii: 1'b0, exp_busy: 19, exp_min_hi: 0,  exp_hi: 25, exp_lo: 25, exp_lag: 12};
    vecs[3] = '{req: 2'b10, exp_speed: 2'b10, exp_gmii: 1'b1, exp_busy: 65, exp_min_hi: 25, exp_hi: 0,  exp_lo: 0,  exp_lag: 0};
    vecs[4] = '{req: 2'b01, exp_speed: 2'b01, exp_gmii: 1'b0, exp_busy: 19, exp_min_hi: 0,  exp_hi: 2,  exp_lo: 3,  exp_lag: 1};
    vecs[5] = '{req: 2'b00, exp_speed: 2'b00, exp_gmii: 1'b0, exp_busy: 20, exp_min_hi: 2,  exp_hi: 25, exp_lo: 25, exp_lag: 12};

    // Reset state and first edges after release
    tick(); tick(); tick();
    chk("rst_tx_clk", tx_clk, 0);
    chk("rst_tx_clk90", tx_clk90, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pause", tx_pause, 0);
    chk("rst_speed", cur_speed, 0);
    chk("rst_gmii", gmii_mode, 0);
    chk("rst_terr", timeout_err, 0);
    reset = 1'b0;
    tick();
    chk("c1_tx_clk", tx_clk, 1);
    chk("c1_tx_clk90", tx_clk90, 0);
    chk("c1_busy", busy, 0);
    repeat (11) tick();
    chk("c12_tx_clk90", tx_clk90, 0);
    tick();
    chk("c13_tx_clk90", tx_clk90, 1);
    check_wave("rst_wave", 25, 25, 12);

    // Table of speed switches, each issued at the start of a high phase
    for (int i = 0; i < 6; i++) begin
      hirun  = (tx_clk === 1'b1) ? 1 : 0;
      lowrun = 0; maxlow = 0; minhi = 999;
      speed_req = vecs[i].req;
      tick(); track();
      chk($sformatf("v%0d_pause", i), tx_pause, 1);
      chk($sformatf("v%0d_busy", i), busy, 1);
      bcyc = (busy === 1'b1) ? 1 : 0;
      for (int k = 0; k < 300 && busy === 1'b1; k++) begin
        tick(); track();
        if (busy === 1'b1) bcyc++;
      end
      chk($sformatf("v%0d_busy_cycles", i), bcyc, vecs[i].exp_busy);
      chk($sformatf("v%0d_speed", i), cur_speed, vecs[i].exp_speed);
      chk($sformatf("v%0d_gmii", i), gmii_mode, vecs[i].exp_gmii);
      chk($sformatf("v%0d_pause_clr", i), tx_pause, 0);
      chk($sformatf("v%0d_first_edge", i), tx_clk, !vecs[i].exp_gmii);
      chk($sformatf("v%0d_settle_low", i), maxlow >= 16, 1);
      if (vecs[i].exp_min_hi > 0)
        chk($sformatf("v%0d_no_runt", i), minhi >= vecs[i].exp_min_hi, 1);
      if (vecs[i].exp_gmii) begin
        highs = 0;
        repeat (40) begin tick(); if (tx_clk !== 1'b0 || tx_clk90 !== 1'b0) highs++; end
        chk($sformatf("v%0d_gmii_low", i), highs, 0);
      end else begin
        check_wave($sformatf("v%0d_wave", i), vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_lag);
      end
    end

    // Reserved request ignored; request changed during GATED queues a second switch
    speed_req = 2'b11;
    repeat (5) tick();
    chk("rsvd_busy", busy, 0);
    chk("rsvd_pause", tx_pause, 0);
    chk("rsvd_speed", cur_speed, 0);
    speed_req = 2'b01;
    tick();
    bcyc = (busy === 1'b1) ? 1 : 0;
    for (int k = 0; k < 300 && busy === 1'b1; k++) begin
      tick();
      if (busy === 1'b1) bcyc++;
      if (bcyc == 50) speed_req = 2'b00;
    end
    chk("b2b_first_cycles", bcyc, 60);
    chk("b2b_first_speed", cur_speed, 1);
    chk("b2b_first_pause", tx_pause, 0);
    tick();
    chk("b2b_second_pause", tx_pause, 1);
    chk("b2b_second_busy", busy, 1);
    bcyc = (busy === 1'b1) ? 1 : 0;
    for (int k = 0; k < 300 && busy === 1'b1; k++) begin
      tick();
      if (busy === 1'b1) bcyc++;
    end
    chk("b2b_second_cycles", bcyc, 20);
    chk("b2b_second_speed", cur_speed, 0);
    check_wave("b2b_wave", 25, 25, 12);

    // tx_idle held low
    tx_idle   = 1'b0;
    speed_req = 2'b01;
    tick();
    chk("stall_pause", tx_pause, 1);
`ifdef ETH_SPEED_CTRL_TIMEOUT_EN
    terr_mid = -1;
    bcyc = (busy === 1'b1) ? 1 : 0;
    for (int k = 0; k < 5000 && busy === 1'b1; k++) begin
      tick();
      if (busy === 1'b1) bcyc++;
      if (bcyc == 4000) terr_mid = timeout_err;
    end
    chk("to_err_mid", terr_mid, 0);
    chk("to_err_set", timeout_err, 1);
    chk("to_cycles_min", bcyc >= 4114, 1);
    chk("to_cycles_max", bcyc <= 4163, 1);
    chk("to_speed", cur_speed, 1);
`else
    drops = 0;
    repeat (10000) begin
      tick();
      if (busy !== 1'b1) drops++;
    end
    chk("stall_busy_drops", drops, 0);
    chk("stall_pause_held", tx_pause, 1);
    chk("stall_terr", timeout_err, 0);
    chk("stall_speed", cur_speed, 0);
`endif

    // Reset asserted while the clocks are gated
    tx_idle   = 1'b1;
    speed_req = (cur_speed == 2'b01) ? 2'b00 : 2'b01;
    lowrun = 0; maxlow = 0; hirun = 0; minhi = 999; found = 0;
    for (int k = 0; k < 300; k++) begin
      tick(); track();
      if (busy === 1'b1 && lowrun >= 14) begin
        found = 1;
        break;
      end
    end
    chk("gated_reached", found, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pause", tx_pause, 0);
    chk("mid_rst_speed", cur_speed, 0);
    chk("mid_rst_gmii", gmii_mode, 0);
    chk("mid_rst_terr", timeout_err, 0);
    chk("mid_rst_tx_clk", tx_clk, 0);
    chk("mid_rst_tx_clk90", tx_clk90, 0);
    speed_req = 2'b00;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("post_rst_c1_tx_clk", tx_clk, 1);
    chk("post_rst_busy", busy, 0);
    check_wave("post_rst_wave", 25, 25, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/eth_speed_ctrl.md
# eth_speed_ctrl

Link-speed controller and programmable transmit-clock divider for the Ethernet MAC, running in the 125 MHz receive-clock domain. It generates the divided `tx_clk`/`tx_clk90` pair for 10 Mbps (2.5 MHz) and 100 Mbps (25 MHz) operation, and flags 1000 Mbps so the top level selects the raw 125 MHz clock. On a speed change it pauses the MAC transmitter, stops the divider at a low phase, holds both clocks low for a settle window, loads the new period and resumes, so no clock edge is ever shortened.

## Interface
Parameters:
- `SETTLE_CYCLES`, 16: rx_clk125 cycles both clocks are held low between stop and restart (≥1).
- `IDLE_TIMEOUT`, 4096: maximum cycles to wait for `tx_idle` (used only with the timeout feature).

Ports:
- `rx_clk125`  in  1  125 MHz clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `speed_req`  in  2  requested speed, synchronous to rx_clk125: 00 = 10M, 01 = 100M, 10 = 1000M, 11 = reserved.
- `tx_idle`  in  1  MAC transmitter idle; it is required only while `tx_pause` = 1.
- `tx_pause`  out  1  request to the MAC to stop starting frames.
- `cur_speed`  out  2  speed currently in effect.
- `gmii_mode`  out  1  1 = top level drives TX from rx_clk125.
- `busy`  out  1  switch in progress (state ≠ RUN).
- `timeout_err`  out  1  sticky; set when a switch was forced after a timeout.
- `tx_clk`  out  1  registered divided clock.
- `tx_clk90`  out  1  registered clock lagging `tx_clk` by about 90°.

## Operation
- Divider: 6-bit `counter` counts 0..P−1 and wraps. P = 50 (10M) or 5 (100M). H = floor(P/2) and Q = floor(P/4), giving H = 25, Q = 12 for 10M and H = 2, Q = 1 for 100M.
  - `tx_clk` next value = (counter < H).
  - `tx_clk90` next value = (Q ≤ counter < Q+H).
  - At counter = P−1 both clocks are low.
- In 1000M mode the counter is held at 0, both clocks are low and `gmii_mode` = 1.
- FSM states: RUN, PAUSE, DRAIN, GATED, LOAD.
  - RUN: if `speed_req` ≠ `cur_speed` and `speed_req` ≠ 11, latch `target` ← `speed_req`, assert `tx_pause` and go to PAUSE. A value of 11 is ignored.
  - PAUSE: when `tx_idle` = 1, go to DRAIN.
  - DRAIN: when counter = P−1, or the current mode is 1000M, go to GATED. Clear `gmii_mode` on entry to GATED.
  - GATED: counter held at 0, clocks forced low, a cycle counter runs for `SETTLE_CYCLES`, then go to LOAD.
  - LOAD: one cycle. `cur_speed` ← `target`, the new P takes effect, counter = 0, `gmii_mode` ← (target = 1000M), `tx_pause` ← 0, then go to RUN.
- `speed_req` changes after the latch have no effect on the switch in progress. They are re-evaluated in the first RUN cycle after LOAD, which can start a back-to-back switch.
- `reset` may assert mid-switch. All state returns to reset values immediately, with no settle window.

## Timing
- Reset values:
  - `cur_speed` = 00; counter = 0; FSM = RUN.
  - `tx_pause`, `busy`, `gmii_mode`, `timeout_err`, `tx_clk`, `tx_clk90` all = 0.
- `tx_clk`/`tx_clk90` are registered one cycle after the counter compare.
  - After reset, the first `tx_clk` high appears in cycle 1.
  - The first `tx_clk90` high appears in cycle Q+1.
- Request to `tx_pause`: 1 cycle (registered).
- `tx_idle` to DRAIN: 1 cycle.
- Total switch time = 1 + idle wait + drain (≤ P cycles) + `SETTLE_CYCLES` + 1 (LOAD).
- `busy` is high from the cycle after the request through LOAD.
- The first new-rate `tx_clk` rising edge is 1 cycle after LOAD.
- A pulse of either clock is never shortened: no high phase is shorter than H cycles, and no low phase is shorter than P−H cycles.

## Configuration
- `ETH_SPEED_CTRL_TIMEOUT_EN` defined:
  - A watchdog counts cycles in PAUSE.
  - After `IDLE_TIMEOUT` cycles without `tx_idle`, the FSM proceeds to DRAIN and sets `timeout_err`.
  - `timeout_err` clears only on reset.
- Not defined: PAUSE waits indefinitely, `timeout_err` is tied 0, and `IDLE_TIMEOUT` is unused.

## Structure
- Shared package `eth_pkg` holds:
  - speed codes SPEED_10 / SPEED_100 / SPEED_1000 / SPEED_RSVD;
  - FSM state encodings;
  - per-speed P, H and Q constants.
- Sub-module `eth_clk_gen`: counter plus compare registers. Inputs are period, halt and reload; outputs are `tx_clk`, `tx_clk90` and a `last` flag (counter = P−1). The FSM lives in the top module.

## Test plan
- Reset, with `speed_req` = 00: `tx_clk` is a 25-high/25-low square wave; each `tx_clk90` rising edge follows the `tx_clk` rising edge by 12 cycles; `busy` = 0.
- `speed_req` 00→01 with `tx_idle` tied 1: `tx_pause` goes high 1 cycle later; both clocks stay low for ≥ `SETTLE_CYCLES`; then `tx_clk` is a 2-high/3-low wave; `cur_speed` = 01; no runt pulses.
- `speed_req` 01→10: `gmii_mode` rises in LOAD, both clocks stay low, `cur_speed` = 10. Then 10→00: DRAIN is immediate, and 10M clocks resume after settle.
- `speed_req` = 11 in RUN, then 01→00 changed again during GATED: the 11 is ignored; the first switch completes, then a second switch to 00 starts in the first RUN cycle after LOAD.
- `tx_idle` held 0:
  - With the macro defined, DRAIN is entered after 4096 cycles and `timeout_err` = 1.
  - Without the macro, `busy` stays 1 for 10000 cycles.
- `reset` asserted during GATED: all outputs reach reset values immediately, and 10M clocking resumes in cycle 1 after release.
